// File: rtl/compositor_pkg.sv
// Shared types, defaults and helpers for the layer compositor.
// Colours are packed {r,g,b}, one CW-bit field per channel.
package compositor_pkg;

  localparam int N_LAYERS_DEF = 4;
  localparam int XW_DEF       = 11;
  localparam int YW_DEF       = 10;
  localparam int CW_DEF       = 4;
  localparam int CW_MAX       = 8;
  localparam int RGB_MAX_W    = 3 * CW_MAX;
  localparam int N_MAX        = 8;

  typedef struct packed {
    logic [CW_DEF-1:0] r;
    logic [CW_DEF-1:0] g;
    logic [CW_DEF-1:0] b;
  } rgb_t;

  // Callers zero-extend narrower colours to the widest supported width.
  function automatic logic key_match(
    input logic [RGB_MAX_W-1:0] a,
    input logic [RGB_MAX_W-1:0] b
  );
    return a == b;
  endfunction

  function automatic logic multi_hot(
    input logic [N_MAX-1:0] v
  );
    return (v & (v - N_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/layer_hit.sv
// One layer's bounds and colour-key test, purely combinational.
// Sums are one bit wider than the coordinates so they cannot wrap.
import compositor_pkg::*;

module layer_hit #(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            i_en,
  input  logic            i_valid,
  input  logic [XW-1:0]   i_x,
  input  logic [YW-1:0]   i_y,
  input  logic [XW-1:0]   i_px,
  input  logic [YW-1:0]   i_py,
  input  logic [XW-1:0]   i_w,
  input  logic [YW-1:0]   i_h,
  input  logic [3*CW-1:0] i_rgb,
  input  logic            i_key_en,
  input  logic [3*CW-1:0] i_key,
  output logic            o_opaque
);

  logic [XW:0] w_x_end;
  logic [YW:0] w_y_end;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_hit;
  logic        w_keyed;

  assign w_x_end = {1'b0, i_px} + {1'b0, i_w};
  assign w_y_end = {1'b0, i_py} + {1'b0, i_h};

  assign w_in_x = (i_x >= i_px) && ({1'b0, i_x} < w_x_end);
  assign w_in_y = (i_y >= i_py) && ({1'b0, i_y} < w_y_end);

  assign w_hit = i_en & i_valid & w_in_x & w_in_y;

  assign w_keyed = i_key_en &
    key_match(RGB_MAX_W'(i_rgb), RGB_MAX_W'(i_key));

  assign o_opaque = w_hit & ~w_keyed;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor: hit test, then priority select.
// Geometry is shadowed at frame_start; collisions reported per frame.
import compositor_pkg::*;

module layer_compositor #(
  parameter int N_LAYERS = N_LAYERS_DEF,
  parameter int XW       = XW_DEF,
  parameter int YW       = YW_DEF,
  parameter int CW       = CW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_valid_i,
  input  logic [XW-1:0]            draw_x,
  input  logic [YW-1:0]            draw_y,
  input  logic                     hsync_i,
  input  logic                     vsync_i,
  input  logic                     frame_start,
  input  logic [N_LAYERS-1:0]      layer_en,
  input  logic [N_LAYERS*XW-1:0]   pos_x,
  input  logic [N_LAYERS*YW-1:0]   pos_y,
  input  logic [N_LAYERS*XW-1:0]   size_w,
  input  logic [N_LAYERS*YW-1:0]   size_h,
  input  logic [N_LAYERS*3*CW-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]      key_en,
  input  logic [3*CW-1:0]          key_color,
  input  logic [3*CW-1:0]          bg_color,
  output logic [CW-1:0]            o_pix_r,
  output logic [CW-1:0]            o_pix_g,
  output logic [CW-1:0]            o_pix_b,
  output logic                     pix_valid_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic [N_LAYERS-1:0]      collision,
  output logic                     collision_valid
);

  localparam int RW = 3 * CW;

  logic [N_LAYERS-1:0]    r_sh_en;
  logic [N_LAYERS-1:0]    r_sh_key_en;
  logic [N_LAYERS*XW-1:0] r_sh_px;
  logic [N_LAYERS*YW-1:0] r_sh_py;
  logic [N_LAYERS*XW-1:0] r_sh_w;
  logic [N_LAYERS*YW-1:0] r_sh_h;

  logic [N_LAYERS-1:0] w_opq;

  logic [N_LAYERS-1:0]    r_s1_opq;
  logic [N_LAYERS*RW-1:0] r_s1_rgb;
  logic [RW-1:0]          r_s1_bg;
  logic                   r_s1_valid;
  logic                   r_s1_hs;
  logic                   r_s1_vs;
  logic                   r_s1_fs;

  logic [RW-1:0] w_sel;
  logic [RW-1:0] r_pix;
  logic          r_valid;
  logic          r_hs;
  logic          r_vs;

  logic [N_LAYERS-1:0] w_c0;
  logic [N_LAYERS-1:0] w_c1;
  logic [N_LAYERS-1:0] r_acc;
  logic [N_LAYERS-1:0] r_coll;
  logic                r_coll_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_en     <= '0;
      r_sh_key_en <= '0;
      r_sh_px     <= '0;
      r_sh_py     <= '0;
      r_sh_w      <= '0;
      r_sh_h      <= '0;
    end else if (frame_start) begin
      r_sh_en     <= layer_en;
      r_sh_key_en <= key_en;
      r_sh_px     <= pos_x;
      r_sh_py     <= pos_y;
      r_sh_w      <= size_w;
      r_sh_h      <= size_h;
    end
  end

  for (genvar gi = 0; gi < N_LAYERS; gi++) begin : g_hit
    layer_hit #(
      .XW (XW),
      .YW (YW),
      .CW (CW)
    ) u_hit (
      .i_en     (r_sh_en[gi]),
      .i_valid  (pix_valid_i),
      .i_x      (draw_x),
      .i_y      (draw_y),
      .i_px     (r_sh_px[gi*XW +: XW]),
      .i_py     (r_sh_py[gi*YW +: YW]),
      .i_w      (r_sh_w[gi*XW +: XW]),
      .i_h      (r_sh_h[gi*YW +: YW]),
      .i_rgb    (layer_rgb[gi*RW +: RW]),
      .i_key_en (r_sh_key_en[gi]),
      .i_key    (key_color),
      .o_opaque (w_opq[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_opq   <= '0;
      r_s1_rgb   <= '0;
      r_s1_bg    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_fs    <= 1'b0;
    end else begin
      r_s1_opq   <= w_opq;
      r_s1_rgb   <= layer_rgb;
      r_s1_bg    <= bg_color;
      r_s1_valid <= pix_valid_i;
      r_s1_hs    <= hsync_i;
      r_s1_vs    <= vsync_i;
      r_s1_fs    <= frame_start;
    end
  end

  // Descending scan so the lowest opaque layer wins.
  always_comb begin
    w_sel = r_s1_bg;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (r_s1_opq[i]) w_sel = r_s1_rgb[i*RW +: RW];
    end
    if (!r_s1_valid) w_sel = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
    end else begin
      r_pix   <= w_sel;
      r_valid <= r_s1_valid;
      r_hs    <= r_s1_hs;
      r_vs    <= r_s1_vs;
    end
  end

  // A pixel sharing a cycle with frame_start belongs to the closing
  // frame, so it is folded in directly and skipped one cycle later.
  assign w_c0 = multi_hot(N_MAX'(w_opq)) ? w_opq : '0;
  assign w_c1 = (!r_s1_fs && multi_hot(N_MAX'(r_s1_opq)))
              ? r_s1_opq : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_coll   <= '0;
      r_coll_v <= 1'b0;
    end else begin
      r_coll_v <= frame_start;
      if (frame_start) begin
        r_coll <= r_acc | w_c1 | w_c0;
        r_acc  <= '0;
      end else begin
        r_acc  <= r_acc | w_c1;
      end
    end
  end

  assign o_pix_r         = r_pix[RW-1 -: CW];
  assign o_pix_g         = r_pix[2*CW-1 -: CW];
  assign o_pix_b         = r_pix[CW-1:0];
  assign pix_valid_o     = r_valid;
  assign hsync_o         = r_hs;
  assign vsync_o         = r_vs;
  assign collision       = r_coll;
  assign collision_valid = r_coll_v;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor with hand-computed colours.
// Each px step checks the pixel applied on the previous step.
module tb_layer_compositor;
  import compositor_pkg::*;

  localparam int N  = 4;
  localparam int XW = 11;
  localparam int YW = 10;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pix_valid_i = 1'b0;
  logic [XW-1:0] draw_x = '0;
  logic [YW-1:0] draw_y = '0;
  logic hsync_i = 1'b0;
  logic vsync_i = 1'b0;
  logic frame_start = 1'b0;
  logic [N-1:0] layer_en = '0;
  logic [N*XW-1:0] pos_x = '0;
  logic [N*YW-1:0] pos_y = '0;
  logic [N*XW-1:0] size_w = '0;
  logic [N*YW-1:0] size_h = '0;
  logic [N*3*CW-1:0] layer_rgb = '0;
  logic [N-1:0] key_en = '0;
  logic [3*CW-1:0] key_color = '0;
  logic [3*CW-1:0] bg_color = '0;
  logic [CW-1:0] o_pix_r, o_pix_g, o_pix_b;
  logic pix_valid_o, hsync_o, vsync_o;
  logic [N-1:0] collision;
  logic collision_valid;

  layer_compositor #(
    .N_LAYERS (N),
    .XW       (XW),
    .YW       (YW),
    .CW       (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pix_valid_i     (pix_valid_i),
    .draw_x          (draw_x),
    .draw_y          (draw_y),
    .hsync_i         (hsync_i),
    .vsync_i         (vsync_i),
    .frame_start     (frame_start),
    .layer_en        (layer_en),
    .pos_x           (pos_x),
    .pos_y           (pos_y),
    .size_w          (size_w),
    .size_h          (size_h),
    .layer_rgb       (layer_rgb),
    .key_en          (key_en),
    .key_color       (key_color),
    .bg_color        (bg_color),
    .o_pix_r         (o_pix_r),
    .o_pix_g         (o_pix_g),
    .o_pix_b         (o_pix_b),
    .pix_valid_o     (pix_valid_o),
    .hsync_o         (hsync_o),
    .vsync_o         (vsync_o),
    .collision       (collision),
    .collision_valid (collision_valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [14:0] exp_q = '0;
  string tag_q = "reset_flush";

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_layer(input int i, input int x, input int y,
                           input int w, input int h,
                           input logic [11:0] rgb);
    pos_x[i*XW +: XW]  = XW'(x);
    pos_y[i*YW +: YW]  = YW'(y);
    size_w[i*XW +: XW] = XW'(w);
    size_h[i*YW +: YW] = YW'(h);
    layer_rgb[i*12 +: 12] = rgb;
  endtask

  task automatic px(input string tag, input int x, input int y,
                    input logic v, input logic fs, input logic hs,
                    input logic vs, input logic [11:0] e);
    draw_x = XW'(x);
    draw_y = YW'(y);
    pix_valid_i = v;
    frame_start = fs;
    hsync_i = hs;
    vsync_i = vs;
    @(posedge clk);
    #1;
    chk(tag_q, 32'({o_pix_r, o_pix_g, o_pix_b,
                    pix_valid_o, hsync_o, vsync_o}), 32'(exp_q));
    exp_q = {v ? e : 12'h000, v, hs, vs};
    tag_q = tag;
    frame_start = 1'b0;
    hsync_i = 1'b0;
    vsync_i = 1'b0;
  endtask

  task automatic fs_step(input string tag);
    px(tag, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic blank(input string tag);
    px(tag, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({o_pix_r, o_pix_g, o_pix_b, pix_valid_o,
        hsync_o, vsync_o, collision, collision_valid}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // single layer sweep
    bg_color = 12'h00F;
    set_layer(0, 100, 50, 20, 10, 12'hF00);
    layer_en = 4'b0001;
    fs_step("fs1");
    chk("fs1_coll", 32'(collision), 32'h0);
    chk("fs1_cvalid", 32'(collision_valid), 32'h1);
    for (int x = 99; x <= 120; x++) begin
      px($sformatf("sweep_x%0d", x), x, 55, 1'b1, 1'b0, 1'b0, 1'b0,
         (x >= 100 && x < 120) ? 12'hF00 : 12'h00F);
      if (x == 99) chk("cvalid_pulse", 32'(collision_valid), 32'h0);
    end
    blank("sweep_end");

    // mid-frame move is invisible until frame_start
    pos_x[0 +: XW] = 11'd200;
    px("old_x100", 100, 55, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    px("old_x200", 200, 55, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    fs_step("fs_move");
    px("new_x100", 100, 55, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    px("new_x200", 200, 55, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    blank("move_end");

    // overlap, priority and collision
    set_layer(0, 10, 10, 4, 4, 12'h0F0);
    set_layer(1, 8, 8, 8, 8, 12'hF00);
    layer_en = 4'b0011;
    fs_step("fs_ovl");
    px("ovl_10", 10, 10, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F0);
    px("ovl_14", 14, 14, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    px("ovl_12", 12, 12, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0F0);
    fs_step("fs_ovl_end");
    chk("coll_overlap", 32'(collision), 32'h3);
    chk("coll_overlap_v", 32'(collision_valid), 32'h1);

    // keyed top layer lets layer 1 through
    key_en = 4'b0001;
    key_color = 12'h0F0;
    fs_step("fs_key");
    chk("coll_empty", 32'(collision), 32'h0);
    px("key_10", 10, 10, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    px("key_5", 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    fs_step("fs_key_end");
    chk("coll_keyed", 32'(collision), 32'h0);

    // no wraparound past the right edge, zero width never hits
    key_en = 4'b0000;
    layer_en = 4'b0001;
    set_layer(0, 2040, 0, 20, 10, 12'hF00);
    fs_step("fs_wrap");
    px("wrap_x0", 0, 2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    px("wrap_x15", 15, 2, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    px("wrap_x2045", 2045, 2, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    px("wrap_x2047", 2047, 2, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    set_layer(0, 0, 0, 0, 10, 12'hF00);
    fs_step("fs_w0");
    px("w0_00", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    px("w0_55", 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);

    // blanking and sync alignment
    set_layer(0, 100, 50, 20, 10, 12'hF00);
    fs_step("fs_blank");
    px("inval_inbounds", 105, 55, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    px("hsync_pulse", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    px("vsync_pulse", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
    px("both_sync", 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    px("valid_after", 110, 55, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    blank("sync_end");

    // frame_start during a valid pixel uses old shadows, old frame
    set_layer(0, 10, 10, 4, 4, 12'h0F0);
    set_layer(1, 8, 8, 8, 8, 12'hF00);
    layer_en = 4'b0011;
    fs_step("fs_pv");
    chk("coll_pv_prev", 32'(collision), 32'h0);
    pos_x[0 +: XW] = 11'd100;
    px("pv_fs_pix", 10, 10, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0F0);
    chk("coll_pv_close", 32'(collision), 32'h3);
    px("pv_new_pix", 10, 10, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    fs_step("fs_pv_end");
    chk("coll_pv_next", 32'(collision), 32'h0);

    // asynchronous reset mid-frame
    px("pre_rst_a", 12, 12, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    px("pre_rst_b", 12, 12, 1'b1, 1'b0, 1'b0, 1'b0, 12'hF00);
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({o_pix_r, o_pix_g, o_pix_b, pix_valid_o,
        hsync_o, vsync_o, collision, collision_valid}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '0;
    tag_q = "post_rst_flush";
    px("post_rst_bg", 10, 10, 1'b1, 1'b0, 1'b0, 1'b0, 12'h00F);
    chk("post_rst_coll", 32'({collision, collision_valid}), 32'h0);
    blank("post_rst_end");
    blank("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
